// File: rtl/counter_sequencer.sv
// Command sequencer for univ_bin_counter: prescaler tick, button edge detection,
// and the run/hold, up/down mode FSM with optional bounce at the count limits.
module counter_sequencer #(
  parameter int unsigned DIV = 67_108_864
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_clr,
  input  logic       btn_load,
  input  logic       btn_pause,
  input  logic       btn_dir,
  input  logic       bounce,
  input  logic       max_tick,
  input  logic       min_tick,
  output logic       syn_clr,
  output logic       load,
  output logic       en,
  output logic       up,
  output logic       tick,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PreLast = PW'(DIV - 1);
  localparam logic [PW-1:0] PrePen  = PW'(DIV - 2);

  typedef enum logic [1:0] {
    StRunUp  = 2'b00,
    StRunDn  = 2'b01,
    StHoldUp = 2'b10,
    StHoldDn = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic [3:0]    btn, btn_q, press;
  logic          syn_clr_q, load_q;
  logic          bounce_hit;

  // Prescaler; tick is registered one count early so it coincides with DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= (presc_q == PreLast) ? '0 : presc_q + PW'(1);
      tick_q  <= (presc_q == PrePen);
    end
  end

  assign btn   = {btn_dir, btn_pause, btn_load, btn_clr};
  assign press = btn & ~btn_q;

  // btn_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q     <= '1;
      syn_clr_q <= 1'b0;
      load_q    <= 1'b0;
      state_q   <= StRunUp;
    end else begin
      btn_q     <= btn;
      syn_clr_q <= press[0];
      load_q    <= press[1] & ~press[0];
      state_q   <= state_d;
    end
  end

  always_comb begin
    en         = tick_q & ~state_q[1] & ~syn_clr_q & ~load_q;
    up         = ~state_q[0];
    bounce_hit = 1'b0;
    if (bounce && state_q == StRunUp && max_tick) begin
      up         = 1'b0;
      bounce_hit = 1'b1;
    end else if (bounce && state_q == StRunDn && min_tick) begin
      up         = 1'b1;
      bounce_hit = 1'b1;
    end

    state_d = state_q;
    if (en && bounce_hit) begin
      state_d = state_e'(state_q ^ 2'b01);
    end
    // A pause/dir press wins over the bounce turn and applies to the current state.
    if (press[1:0] == 2'b00) begin
      if (press[2]) begin
        state_d = state_e'(state_q ^ 2'b10);
      end else if (press[3]) begin
        state_d = state_e'(state_q ^ 2'b01);
      end
    end
  end

  assign syn_clr = syn_clr_q;
  assign load    = load_q;
  assign tick    = tick_q;
  assign state   = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a cycle model pushes expected outputs
// as stimulus is applied; a negedge monitor pops and compares them.
module tb_counter_sequencer;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset, btn_clr, btn_load, btn_pause, btn_dir, bounce, max_tick, min_tick;
  logic       syn_clr, load, en, up, tick;
  logic [1:0] state;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  string phase    = "init";

  // Model of the visible registered behaviour.
  int         m_k;
  logic [1:0] m_state;
  logic       m_clr, m_ld;
  logic [3:0] m_btnq;

  counter_sequencer #(.DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_clr  (btn_clr),
    .btn_load (btn_load),
    .btn_pause(btn_pause),
    .btn_dir  (btn_dir),
    .bounce   (bounce),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .syn_clr  (syn_clr),
    .load     (load),
    .en       (en),
    .up       (up),
    .tick     (tick),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Evaluate the current cycle's inputs, push the expectation, then advance a clock.
  task automatic cycle();
    logic       tk, en_e, up_e, bnc;
    logic [3:0] btn, prs;
    logic [1:0] ns;
    exp_t       e;
    if (reset) begin
      m_k     = 0;
      m_state = 2'b00;
      m_clr   = 1'b0;
      m_ld    = 1'b0;
      m_btnq  = 4'hf;
    end else begin
      tk   = (m_k % DIV) == (DIV - 1);
      en_e = tk && !m_state[1] && !m_clr && !m_ld;
      up_e = !m_state[0];
      bnc  = 1'b0;
      if (bounce && m_state == 2'b00 && max_tick) begin
        up_e = 1'b0;
        bnc  = 1'b1;
      end else if (bounce && m_state == 2'b01 && min_tick) begin
        up_e = 1'b1;
        bnc  = 1'b1;
      end
      e.tag = $sformatf("%s@%0d", phase, cyc);
      e.exp = {m_clr, m_ld, en_e, up_e, tk, m_state};
      sb.push_back(e);

      btn = {btn_dir, btn_pause, btn_load, btn_clr};
      prs = btn & ~m_btnq;
      ns  = m_state;
      if (en_e && bnc) ns[0] = ~m_state[0];
      if (prs[0]) begin
        m_clr = 1'b1;
        m_ld  = 1'b0;
      end else if (prs[1]) begin
        m_clr = 1'b0;
        m_ld  = 1'b1;
      end else begin
        m_clr = 1'b0;
        m_ld  = 1'b0;
        if (prs[2])      ns = {~m_state[1], m_state[0]};
        else if (prs[3]) ns = {m_state[1], ~m_state[0]};
      end
      m_state = ns;
      m_btnq  = btn;
      m_k++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, {25'd0, syn_clr, load, en, up, tick, state}, {25'd0, e.exp});
    end
  end

  initial begin
    reset = 1'b1; btn_clr = 0; btn_load = 0; btn_pause = 0; btn_dir = 0;
    bounce = 0; max_tick = 0; min_tick = 0;
    run(3);

    phase = "freerun";
    reset = 1'b0;
    run(14);

    phase = "held_rst";
    btn_clr = 1; reset = 1;
    run(2);
    reset = 0;
    run(10);
    btn_clr = 0;
    cycle();
    btn_clr = 1;
    run(3);
    btn_clr = 0;
    run(2);

    phase = "simul";
    btn_clr = 1; btn_load = 1; btn_dir = 1;
    run(2);
    btn_clr = 0; btn_load = 0; btn_dir = 0;
    run(3);
    btn_dir = 1;
    cycle();
    btn_dir = 0;
    run(6);
    btn_dir = 1;
    cycle();
    btn_dir = 0;
    run(2);

    phase = "pause";
    btn_pause = 1;
    cycle();
    btn_pause = 0;
    run(14);
    btn_pause = 1;
    cycle();
    btn_pause = 0;
    run(6);

    phase = "bounce";
    bounce = 1; max_tick = 1;
    run(6);
    max_tick = 0; min_tick = 1;
    run(6);
    min_tick = 0;
    run(2);
    bounce = 0; max_tick = 1;
    run(9);
    max_tick = 0;

    phase = "collide";
    while ((m_k % DIV) != 2) cycle();
    btn_load = 1;
    cycle();
    btn_load = 0;
    run(10);

    phase = "midrst";
    btn_clr = 1;
    cycle();
    btn_clr = 0; reset = 1;
    cycle();
    reset = 0;
    run(6);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) btn_clr   = ~btn_clr;
      if ($urandom_range(0, 5) == 0) btn_load  = ~btn_load;
      if ($urandom_range(0, 3) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 3) == 0) btn_dir   = ~btn_dir;
      if ($urandom_range(0, 15) == 0) bounce   = ~bounce;
      max_tick = ($urandom_range(0, 2) == 0);
      min_tick = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 60) == 0);
      cycle();
    end
    reset = 0;
    run(2);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
